// File: rtl/video_sig_decode.sv
// Video timing receiver: rebuilds active-region coordinates, new-frame pulse, frame count and
// timing lock from an hs/vs/ad bus. Define VIDEO_SIG_DECODE_MEASURE_EN to expose measurements.
module video_sig_decode #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int H_FRONT_PORCH   = 110,
    parameter int H_SYNC_WIDTH    = 40,
    parameter int H_BACK_PORCH    = 220,
    parameter int ACTIVE_LINES    = 720,
    parameter int V_FRONT_PORCH   = 5,
    parameter int V_SYNC_WIDTH    = 5,
    parameter int V_BACK_PORCH    = 20,
    parameter int FPS             = 60,
    parameter int LOCK_FRAMES     = 2,
    localparam int TOTAL_PIXELS = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
    localparam int TOTAL_LINES  = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
    localparam int HW  = $clog2(ACTIVE_H_PIXELS),
    localparam int VW  = $clog2(ACTIVE_LINES),
    localparam int HMW = $clog2(2 * TOTAL_PIXELS) + 1,
    localparam int VMW = $clog2(2 * TOTAL_LINES) + 1
) (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          ad_in,
    output logic [HW-1:0] hcount_out,
    output logic [VW-1:0] vcount_out,
    output logic          ad_out,
    output logic          nf_out,
    output logic [5:0]    fc_out,
    output logic          lock_out,
    output logic          err_out
`ifdef VIDEO_SIG_DECODE_MEASURE_EN
    ,
    output logic [HMW-1:0] h_period_out,
    output logic [HMW-1:0] h_act_out,
    output logic [VMW-1:0] v_period_out,
    output logic [VMW-1:0] v_act_out
`endif
);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [HMW-1:0] TP     = HMW'(TOTAL_PIXELS);
    localparam logic [HMW-1:0] AHP    = HMW'(ACTIVE_H_PIXELS);
    localparam logic [VMW-1:0] TL     = VMW'(TOTAL_LINES);
    localparam logic [VMW-1:0] AL     = VMW'(ACTIVE_LINES);
    localparam logic [HW-1:0]  HMAX   = HW'(ACTIVE_H_PIXELS - 1);
    localparam logic [VW-1:0]  VMAX   = VW'(ACTIVE_LINES - 1);
    localparam logic [5:0]     FC_MAX = 6'(FPS - 1);
    localparam logic [GW-1:0]  LOCK_N = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    function automatic logic [HMW-1:0] sat_inc_h(input logic [HMW-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    function automatic logic [VMW-1:0] sat_inc_v(input logic [VMW-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    logic           hs_p1, vs_p1, hs_rise, vs_rise;
    logic [HMW-1:0] h_cnt, h_cnt_n, h_act, h_act_n;
    logic [VMW-1:0] v_cnt, v_cnt_n, v_act, v_act_n;
    logic           line_ad, line_ad_n, frame_ad, frame_ad_n, line_bad, line_bad_n;
    logic           line_fail, frame_match;
    logic [HW-1:0]  hcount_n;
    logic [VW-1:0]  vcount_n;
    logic [5:0]     fc_n;
    logic           lock_n, err_n;
    logic [GW-1:0]  good, good_n;
    state_t         state, state_n;
`ifdef VIDEO_SIG_DECODE_MEASURE_EN
    logic [HMW-1:0] h_per_last, h_act_last;
`endif

    assign hs_rise = hs_in & ~hs_p1;
    assign vs_rise = vs_in & ~vs_p1;

    // Measurement and coordinates: the line check of a coincident hs rise is folded in before the frame check.
    always_comb begin
        h_cnt_n     = sat_inc_h(h_cnt);
        h_act_n     = h_act;
        v_cnt_n     = v_cnt;
        v_act_n     = v_act;
        line_ad_n   = line_ad;
        frame_ad_n  = frame_ad;
        hcount_n    = hcount_out;
        vcount_n    = vcount_out;
        line_fail   = 1'b0;
        frame_match = 1'b0;
        if (hs_rise) begin
            line_fail = (h_cnt != TP) || (line_ad && (h_act != AHP));
            h_cnt_n   = HMW'(1);
            h_act_n   = '0;
            line_ad_n = 1'b0;
            v_cnt_n   = sat_inc_v(v_cnt);
        end
        line_bad_n = line_bad | line_fail;
        if (vs_rise) begin
            frame_match = !line_bad_n && (v_cnt == TL) && (v_act == AL);
            v_cnt_n     = hs_rise ? VMW'(1) : '0;
            v_act_n     = '0;
            frame_ad_n  = 1'b0;
            line_bad_n  = 1'b0;
        end
        if (ad_in) begin
            h_act_n = sat_inc_h(h_act_n);
            if (!line_ad_n) begin
                line_ad_n = 1'b1;
                hcount_n  = '0;
                v_act_n   = sat_inc_v(v_act_n);
                if (!frame_ad_n) begin
                    frame_ad_n = 1'b1;
                    vcount_n   = '0;
                end else if (vcount_out == VMAX) begin
                    line_bad_n = 1'b1;
                end else begin
                    vcount_n = vcount_out + 1'b1;
                end
            end else if (hcount_out == HMAX) begin
                line_bad_n = 1'b1;
            end else begin
                hcount_n = hcount_out + 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        good_n  = good;
        lock_n  = lock_out;
        err_n   = 1'b0;
        fc_n    = fc_out;
        if (vs_rise) fc_n = (fc_out == FC_MAX) ? '0 : fc_out + 1'b1;
        case (state)
            SEARCH: begin
                if (vs_rise) begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                end
            end
            ACQUIRE: begin
                if (vs_rise) begin
                    good_n = frame_match ? good + 1'b1 : '0;
                    if (frame_match && (good_n == LOCK_N)) begin
                        state_n = LOCKED;
                        lock_n  = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (line_fail || (vs_rise && !frame_match)) begin
                    err_n   = 1'b1;
                    lock_n  = 1'b0;
                    good_n  = '0;
                    state_n = SEARCH;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    // Register stage: everything visible one cycle after the sampled inputs.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            hs_p1 <= 1'b0;  vs_p1 <= 1'b0;
            h_cnt <= '0;    h_act <= '0;
            v_cnt <= '0;    v_act <= '0;
            line_ad <= 1'b0; frame_ad <= 1'b0; line_bad <= 1'b0;
            hcount_out <= '0; vcount_out <= '0;
            ad_out <= 1'b0; nf_out <= 1'b0; fc_out <= '0;
            lock_out <= 1'b0; err_out <= 1'b0;
            good <= '0;     state <= SEARCH;
`ifdef VIDEO_SIG_DECODE_MEASURE_EN
            h_per_last <= '0; h_act_last <= '0;
            h_period_out <= '0; h_act_out <= '0;
            v_period_out <= '0; v_act_out <= '0;
`endif
        end else begin
            hs_p1 <= hs_in;  vs_p1 <= vs_in;
            h_cnt <= h_cnt_n; h_act <= h_act_n;
            v_cnt <= v_cnt_n; v_act <= v_act_n;
            line_ad <= line_ad_n; frame_ad <= frame_ad_n; line_bad <= line_bad_n;
            hcount_out <= hcount_n; vcount_out <= vcount_n;
            ad_out <= ad_in; nf_out <= vs_rise; fc_out <= fc_n;
            lock_out <= lock_n; err_out <= err_n;
            good <= good_n;  state <= state_n;
`ifdef VIDEO_SIG_DECODE_MEASURE_EN
            if (hs_rise) begin
                h_per_last <= h_cnt;
                h_act_last <= h_act;
            end
            if (vs_rise) begin
                h_period_out <= hs_rise ? h_cnt : h_per_last;
                h_act_out    <= hs_rise ? h_act : h_act_last;
                v_period_out <= v_cnt;
                v_act_out    <= v_act;
            end
`endif
        end
    end
endmodule

// File: tb/tb_video_sig_decode.sv
// Bench for video_sig_decode on a small 8x4 format: directed frames, per-cycle scoreboard.
module tb_video_sig_decode;
    localparam int AH = 8, HFP = 2, HS = 2, HBP = 2;
    localparam int AL = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int FPS = 4, LF = 2;
    localparam int TOTAL_H = AH + HFP + HS + HBP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, hs = 1'b0, vs = 1'b0, ad = 1'b0;
    logic [2:0] hcount_out;
    logic [1:0] vcount_out;
    logic       ad_out, nf_out, lock_out, err_out;
    logic [5:0] fc_out;
`ifdef VIDEO_SIG_DECODE_MEASURE_EN
    logic [5:0] h_period_out, h_act_out;
    logic [4:0] v_period_out, v_act_out;
`endif

    always #5 clk = ~clk;

    video_sig_decode #(
        .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HS), .H_BACK_PORCH(HBP),
        .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VS), .V_BACK_PORCH(VBP),
        .FPS(FPS), .LOCK_FRAMES(LF)
    ) dut (
        .pixel_clk_in(clk), .rst_in(rst_n), .hs_in(hs), .vs_in(vs), .ad_in(ad),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .ad_out(ad_out), .nf_out(nf_out),
        .fc_out(fc_out), .lock_out(lock_out), .err_out(err_out)
`ifdef VIDEO_SIG_DECODE_MEASURE_EN
        , .h_period_out(h_period_out), .h_act_out(h_act_out)
        , .v_period_out(v_period_out), .v_act_out(v_act_out)
`endif
    );

    typedef struct {
        int         phase;
        logic       ad;
        logic       nf;
        logic [5:0] fc;
        logic       lock;
        logic       err;
        bit         chkpos;
        logic [2:0] h;
        logic [1:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0, n_bad = 0, nf_seen = 0, phase = 0, snap;

    // Frame-level reference: the bench knows which lines and frames it built wrongly.
    bit m_hs_p, m_vs_p, m_lock;
    int m_fc, m_state, m_good;
    bit pend_line_bad, pend_frame_bad, next_line_bad, next_frame_bad;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_cmp++;
            assert ({ad_out, nf_out, fc_out, lock_out, err_out} === {mon_e.ad, mon_e.nf, mon_e.fc, mon_e.lock, mon_e.err})
            else begin
                n_bad++;
                $error("FAIL ctl phase%0d got ad=%0b nf=%0b fc=%0d lock=%0b err=%0b want ad=%0b nf=%0b fc=%0d lock=%0b err=%0b",
                       mon_e.phase, ad_out, nf_out, fc_out, lock_out, err_out,
                       mon_e.ad, mon_e.nf, mon_e.fc, mon_e.lock, mon_e.err);
            end
            if (mon_e.chkpos) begin
                n_cmp++;
                assert ({hcount_out, vcount_out} === {mon_e.h, mon_e.v})
                else begin
                    n_bad++;
                    $error("FAIL pos phase%0d got h=%0d v=%0d want h=%0d v=%0d",
                           mon_e.phase, hcount_out, vcount_out, mon_e.h, mon_e.v);
                end
            end
            if (nf_out === 1'b1) nf_seen++;
        end
    end

    task automatic cyc(input bit h, input bit v, input bit a, input bit r,
                       input bit cp, input int eh, input int ev);
        exp_t e;
        bit hr, vr, lf, fm;
        @(negedge clk);
        #1;
        hs = h; vs = v; ad = a; rst_n = r;
        e.phase = phase; e.chkpos = cp; e.h = 3'(eh); e.v = 2'(ev);
        if (!r) begin
            m_hs_p = 0; m_vs_p = 0; m_fc = 0; m_state = 0; m_good = 0; m_lock = 0;
            pend_line_bad = 1; pend_frame_bad = 1;
            e.ad = 0; e.nf = 0; e.fc = '0; e.lock = 0; e.err = 0;
            e.chkpos = 1; e.h = '0; e.v = '0;
        end else begin
            hr = h && !m_hs_p; vr = v && !m_vs_p; lf = 0; fm = 0; e.err = 0;
            if (hr) begin
                lf = pend_line_bad;
                pend_frame_bad = pend_frame_bad | lf;
                pend_line_bad = next_line_bad;
            end
            if (vr) begin
                fm = !pend_frame_bad;
                pend_frame_bad = next_frame_bad;
                m_fc = (m_fc + 1) % FPS;
            end
            if (m_state == 2 && (lf || (vr && !fm))) begin
                e.err = 1; m_state = 0; m_good = 0; m_lock = 0;
            end else if (vr && m_state == 0) begin
                m_state = 1; m_good = 0;
            end else if (vr && m_state == 1) begin
                m_good = fm ? m_good + 1 : 0;
                if (m_good == LF) begin
                    m_state = 2; m_lock = 1;
                end
            end
            e.ad = a; e.nf = vr; e.fc = 6'(m_fc); e.lock = m_lock;
            m_hs_p = h; m_vs_p = v;
        end
        sb.push_back(e);
    endtask

    task automatic line(input bit vsync, input bit act, input int y, input int adlen,
                        input int fp, input int rst_cyc);
        int body, len, x;
        bit h, a;
        body = act ? adlen : AH;
        len = HS + HBP + body + fp;
        next_line_bad = (len != TOTAL_H) || (act && adlen != AH);
        for (int i = 0; i < len; i++) begin
            h = (i < HS);
            a = act && (i >= HS + HBP) && (i < HS + HBP + body);
            x = i - HS - HBP;
            cyc(h, vsync, a, i != rst_cyc, a, (x > AH - 1) ? AH - 1 : x, (y > AL - 1) ? AL - 1 : y);
        end
    endtask

    task automatic frame(input int nact, input int adlen, input int long_y, input int rst_line);
        int nl, y;
        bit act;
        nl = VS + VBP + nact + VFP;
        next_frame_bad = (nact != AL);
        for (int l = 0; l < nl; l++) begin
            act = (l >= VS + VBP) && (l < VS + VBP + nact);
            y = l - VS - VBP;
            line(l < VS, act, y, adlen, (act && y == long_y) ? HFP + 1 : HFP,
                 (l == rst_line) ? HS + HBP + AH : -1);
        end
    endtask

    initial begin
        phase = 0;
        repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
        repeat (5) cyc(0, 0, 0, 1, 0, 0, 0);

        phase = 1;
        repeat (4) frame(AL, AH, -1, -1);
        n_cmp++;
        assert (lock_out === 1'b1) else begin
            n_bad++; $error("FAIL lock_after_4 got %0b want 1", lock_out);
        end

        phase = 3;
        snap = nf_seen;
        repeat (6) frame(AL, AH, -1, -1);
        n_cmp++;
        assert (nf_seen - snap == 6) else begin
            n_bad++; $error("FAIL nf_count got %0d want 6", nf_seen - snap);
        end
        n_cmp++;
        assert (fc_out === 6'd2) else begin
            n_bad++; $error("FAIL fc_after_6 got %0d want 2", fc_out);
        end

        phase = 4;
        frame(AL, AH, 1, -1);
        n_cmp++;
        assert (lock_out === 1'b0) else begin
            n_bad++; $error("FAIL lock_after_long got %0b want 0", lock_out);
        end
        repeat (3) frame(AL, AH, -1, -1);
        n_cmp++;
        assert (lock_out === 1'b1) else begin
            n_bad++; $error("FAIL relock got %0b want 1", lock_out);
        end

        phase = 5;
        repeat (2) frame(AL + 1, AH + 1, -1, -1);
        n_cmp++;
        assert (lock_out === 1'b0) else begin
            n_bad++; $error("FAIL lock_after_sat got %0b want 0", lock_out);
        end

        phase = 6;
        frame(AL, AH, -1, -1);
        frame(AL, AH, -1, VS + VBP + AL);
        n_cmp++;
        assert (lock_out === 1'b0) else begin
            n_bad++; $error("FAIL lock_after_rst got %0b want 0", lock_out);
        end
        repeat (4) frame(AL, AH, -1, -1);
        n_cmp++;
        assert (lock_out === 1'b1) else begin
            n_bad++; $error("FAIL relock_after_rst got %0b want 1", lock_out);
        end

        repeat (3) cyc(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        #2;
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++; $error("FAIL drain got %0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
